riscv_dmem: RTL and testbench

RISCV_DMEM -- requirements
Module: riscv_dmem

---
 rtl/riscv_dmem_pkg.sv | 18 +
 rtl/riscv_dmem_array.sv | 24 ++
 rtl/riscv_dmem.sv | 131 +++++++++++++
 tb/tb_riscv_dmem.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_dmem_pkg.sv
// Shared RISC-V package: data-memory state, access classes
// and the default MMIO tohost address.
package riscv_dmem_pkg;

  localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h8000_0000;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_RAM,
    ACC_TOHOST
  } mem_access_t;

  typedef enum logic {
    DMEM_CLEAR,
    DMEM_RUN
  } dmem_state_t;

endpackage

// File: rtl/riscv_dmem_array.sv
// Word RAM: one synchronous write port, one asynchronous
// read port, no reset (contents cleared by the owner's sweep).
module riscv_dmem_array #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/riscv_dmem.sv
// Hart data memory: RAM with post-reset zero sweep, tohost
// MMIO register and sticky store-fault flag.
module riscv_dmem
  import riscv_dmem_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 1024,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(TOHOST_ADDR_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_data,
  input  logic            mem_write,
  output logic [XLEN-1:0] mem_read,
  output logic            ready,
  output logic            fault,
  output logic            tohost_valid,
  output logic [XLEN-1:0] tohost_data
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  logic            ram_hit;
  logic            host_hit;
  logic            aligned;
  logic [AW-1:0]   idx;
  mem_access_t     access;

  logic            arr_we;
  logic [AW-1:0]   arr_waddr;
  logic [XLEN-1:0] arr_wdata;
  logic [XLEN-1:0] arr_rdata;

  logic            st_host;
  logic            st_bad;

  assign ram_hit  = ~|mem_addr[XLEN-1:AW+2];
  assign host_hit = (mem_addr == TOHOST_ADDR);
  assign aligned  = (mem_addr[1:0] == 2'b00);
  assign idx      = mem_addr[AW+1:2];

  always_comb begin
    access = ACC_NONE;
    unique case (1'b1)
      host_hit: access = ACC_TOHOST;
      ram_hit:  access = ACC_RAM;
      default:  access = ACC_NONE;
    endcase
  end

  riscv_dmem_array #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .raddr (idx),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= DMEM_CLEAR;
      cnt_q        <= '0;
      fault        <= 1'b0;
      tohost_valid <= 1'b0;
      tohost_data  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      fault        <= fault | st_bad;
      tohost_valid <= st_host;
      if (st_host) tohost_data <= mem_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_waddr = idx;
    arr_wdata = mem_data;
    st_host   = 1'b0;
    st_bad    = 1'b0;
    unique case (state_q)
      DMEM_CLEAR: begin
        // host stores are silently dropped while sweeping
        arr_we    = 1'b1;
        arr_waddr = cnt_q;
        arr_wdata = '0;
        cnt_d     = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) state_d = DMEM_RUN;
      end
      DMEM_RUN: begin
        if (mem_write) begin
          unique case (access)
            ACC_RAM: begin
              if (aligned) arr_we = 1'b1;
              else         st_bad = 1'b1;
            end
            ACC_TOHOST: st_host = 1'b1;
            default:    st_bad  = 1'b1;
          endcase
        end
      end
      default: state_d = DMEM_CLEAR;
    endcase
    if (rst) arr_we = 1'b0;
  end

  assign ready = (state_q == DMEM_RUN);

  always_comb begin
    mem_read = '0;
    if (ready) begin
      unique case (access)
        ACC_RAM:    mem_read = arr_rdata;
        ACC_TOHOST: mem_read = tohost_data;
        default:    mem_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_dmem.sv
// Directed self-checking bench for riscv_dmem with DEPTH=16.
module tb_riscv_dmem;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  logic            clk;
  logic            rst;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_data;
  logic            mem_write;
  logic [XLEN-1:0] mem_read;
  logic            ready;
  logic            fault;
  logic            tohost_valid;
  logic [XLEN-1:0] tohost_data;

  int checks;
  int fails;

  riscv_dmem #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_write    (mem_write),
    .mem_read     (mem_read),
    .ready        (ready),
    .fault        (fault),
    .tohost_valid (tohost_valid),
    .tohost_data  (tohost_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_reset(output int n);
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    wait_ready(n);
  endtask

  task automatic test_reset();
    int n;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    rst = 1'b1;
    tick();
    checks++;
    if (ready !== 1'b0 || fault !== 1'b0 || tohost_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_flags: ready=%b fault=%b valid=%b need 0/0/0",
               ready, fault, tohost_valid);
    end
    checks++;
    if (tohost_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_tohost_data: got %h need 0", tohost_data);
    end
    rst = 1'b0;
    repeat (5) tick();
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL clear_read: got %h need 0", mem_read);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL sweep_cycles: got %0d need 16", n);
    end
    checks++;
    if (ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_after_sweep: got %b need 1", ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      mem_addr = 32'(i * 4);
      #1;
      checks++;
      if (mem_read !== 32'h0) begin
        fails++;
        $display("FAIL word_zero[%0d]: got %h need 0", i, mem_read);
      end
    end
  endtask

  task automatic test_store_load();
    logic [XLEN-1:0] offs [3];
    offs[0] = 32'h0D;
    offs[1] = 32'h0E;
    offs[2] = 32'h0F;
    mem_addr  = 32'h0C;
    mem_data  = 32'hDEAD_BEEF;
    mem_write = 1'b1;
    #1;
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL same_cycle_old: got %h need 0", mem_read);
    end
    tick();
    mem_write = 1'b0;
    #1;
    checks++;
    if (mem_read !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL next_cycle_new: got %h need deadbeef", mem_read);
    end
    for (int i = 0; i < 3; i++) begin
      mem_addr = offs[i];
      #1;
      checks++;
      if (mem_read !== 32'hDEAD_BEEF) begin
        fails++;
        $display("FAIL unaligned_read %h: got %h need deadbeef",
                 offs[i], mem_read);
      end
    end
    mem_addr = 32'h100;
    #1;
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL unmapped_read: got %h need 0", mem_read);
    end
    checks++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL read_no_fault: got %b need 0", fault);
    end
  endtask

  task automatic test_back_to_back();
    mem_addr  = 32'h8000_0000;
    mem_data  = 32'h41;
    mem_write = 1'b1;
    tick();
    checks++;
    if (tohost_valid !== 1'b1 || tohost_data !== 32'h41) begin
      fails++;
      $display("FAIL tohost_first: valid=%b data=%h need 1/41",
               tohost_valid, tohost_data);
    end
    mem_data = 32'h42;
    tick();
    checks++;
    if (tohost_valid !== 1'b1 || tohost_data !== 32'h42) begin
      fails++;
      $display("FAIL tohost_second: valid=%b data=%h need 1/42",
               tohost_valid, tohost_data);
    end
    mem_write = 1'b0;
    tick();
    checks++;
    if (tohost_valid !== 1'b0) begin
      fails++;
      $display("FAIL tohost_pulse_end: got %b need 0", tohost_valid);
    end
    checks++;
    if (mem_read !== 32'h42) begin
      fails++;
      $display("FAIL tohost_read: got %h need 42", mem_read);
    end
    checks++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL tohost_no_fault: got %b need 0", fault);
    end
  endtask

  task automatic test_fault();
    int n;
    do_reset(n);
    mem_addr  = 32'h40;
    mem_data  = 32'h33;
    mem_write = 1'b1;
    tick();
    mem_write = 1'b0;
    mem_addr  = 32'h00;
    #1;
    checks++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_out_of_range: got %b need 1", fault);
    end
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL out_of_range_wrap: got %h need 0", mem_read);
    end
    do_reset(n);
    checks++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL fault_cleared: got %b need 0", fault);
    end
    mem_addr  = 32'h04;
    mem_data  = 32'h1111_1111;
    mem_write = 1'b1;
    tick();
    mem_addr = 32'h06;
    mem_data = 32'h2222_2222;
    tick();
    mem_write = 1'b0;
    mem_addr  = 32'h04;
    #1;
    checks++;
    if (mem_read !== 32'h1111_1111) begin
      fails++;
      $display("FAIL misaligned_dropped: got %h need 11111111", mem_read);
    end
    checks++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_misaligned: got %b need 1", fault);
    end
    repeat (4) tick();
    checks++;
    if (fault !== 1'b1) begin
      fails++;
      $display("FAIL fault_sticky: got %b need 1", fault);
    end
  endtask

  task automatic test_clear_store();
    int n;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_addr  = 32'h00;
    mem_data  = 32'h0000_00AA;
    mem_write = 1'b1;
    wait_ready(n);
    mem_write = 1'b0;
    #1;
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL clear_store_sweep: got %0d need 16", n);
    end
    checks++;
    if (fault !== 1'b0) begin
      fails++;
      $display("FAIL clear_store_fault: got %b need 0", fault);
    end
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL clear_store_dropped: got %h need 0", mem_read);
    end
  endtask

  task automatic test_reset_override();
    int n;
    mem_addr  = 32'h04;
    mem_data  = 32'h1234;
    mem_write = 1'b1;
    tick();
    mem_addr = 32'h08;
    mem_data = 32'h5678;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    mem_write = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b0) begin
      fails++;
      $display("FAIL override_restart: got %b need 0", ready);
    end
    wait_ready(n);
    checks++;
    if (n !== 16) begin
      fails++;
      $display("FAIL override_sweep: got %0d need 16", n);
    end
    mem_addr = 32'h04;
    #1;
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL override_w1: got %h need 0", mem_read);
    end
    mem_addr = 32'h08;
    #1;
    checks++;
    if (mem_read !== 32'h0) begin
      fails++;
      $display("FAIL override_w2: got %h need 0", mem_read);
    end
    checks++;
    if (fault !== 1'b0 || tohost_valid !== 1'b0) begin
      fails++;
      $display("FAIL override_flags: fault=%b valid=%b need 0/0",
               fault, tohost_valid);
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    rst       = 1'b1;
    mem_addr  = '0;
    mem_data  = '0;
    mem_write = 1'b0;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_fault();
    test_clear_store();
    test_reset_override();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
